// File: rtl/alu_bus_sequencer.sv
// alu_bus_sequencer: decode, bus-request and execute sequencer for the 4-bit accumulator ALU.
// Define SEQ_TIMEOUT_EN to build the bus-wait timeout counter and the sticky err flag.
module alu_bus_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  output logic [3:0] busreq,
  output logic [3:0] bus_addr,
  output logic [3:0] bus_wdata,
  input  logic       bus_ack,
  input  logic [3:0] bus_rdata,
  output logic [3:0] acc,
  output logic       carry,
  output logic       zero,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    REQ_RD,
    REQ_WR,
    REQ_OP,
    EXEC
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_LDX  = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;

  localparam logic [3:0] BR_NONE = 4'h0;
  localparam logic [3:0] BR_RD   = 4'h1;
  localparam logic [3:0] BR_WR   = 4'h2;
  localparam logic [3:0] BR_OP   = 4'h3;

  state_t     state;
  logic [7:0] ir;
  logic [3:0] opnd;
  logic [3:0] op;
  logic [3:0] fld;
  logic       is_rd;
  logic       is_st;
  logic       is_ldx;

  assign op     = ir[3:0];
  assign fld    = ir[7:4];
  assign is_rd  = (op >= OP_ADD) && (op <= OP_XOR);
  assign is_st  = (op == OP_ST);
  assign is_ldx = (op == OP_LDX);

  assign busy        = (state != IDLE);
  assign instr_ready = (state == IDLE) && ena;

  logic [4:0] sum;
  logic [4:0] diff;
  logic [3:0] res;
  logic       c_new;
  logic       wr_acc;
  logic       wr_carry;

  always_comb begin
    res      = acc;
    c_new    = carry;
    wr_acc   = 1'b0;
    wr_carry = 1'b0;
    sum      = {1'b0, acc} + {1'b0, (op == OP_ADDI) ? fld : opnd};
    diff     = {1'b0, acc} - {1'b0, opnd};
    case (op)
      OP_ADDI, OP_ADD: begin
        res      = sum[3:0];
        c_new    = sum[4];
        wr_acc   = 1'b1;
        wr_carry = 1'b1;
      end
      OP_SUB: begin
        res      = diff[3:0];
        c_new    = diff[4];
        wr_acc   = 1'b1;
        wr_carry = 1'b1;
      end
      OP_AND: begin
        res    = acc & opnd;
        wr_acc = 1'b1;
      end
      OP_OR: begin
        res    = acc | opnd;
        wr_acc = 1'b1;
      end
      OP_XOR: begin
        res    = acc ^ opnd;
        wr_acc = 1'b1;
      end
      OP_LDI: begin
        res    = fld;
        wr_acc = 1'b1;
      end
      OP_LDX: begin
        res    = opnd;
        wr_acc = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       timed_out;
  assign timed_out = (wait_cnt == TO_LAST);
`else
  assign err = 1'b0;
  // Without the wait counter the limit has no consumer
  if (TIMEOUT == 0) begin : g_no_timeout
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ir        <= '0;
      opnd      <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      busreq    <= BR_NONE;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (instr_valid && instr_ready) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
`ifdef SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          unique case (1'b1)
            is_rd: begin
              state    <= REQ_RD;
              busreq   <= BR_RD;
              bus_addr <= fld;
            end
            is_st: begin
              state     <= REQ_WR;
              busreq    <= BR_WR;
              bus_addr  <= fld;
              bus_wdata <= acc;
            end
            is_ldx: begin
              state  <= REQ_OP;
              busreq <= BR_OP;
            end
            default: state <= EXEC;
          endcase
        end
        REQ_RD, REQ_WR, REQ_OP: begin
          if (bus_ack) begin
            opnd      <= bus_rdata;
            state     <= EXEC;
            busreq    <= BR_NONE;
            bus_addr  <= '0;
            bus_wdata <= '0;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (timed_out) begin
            state     <= IDLE;
            err       <= 1'b1;
            busreq    <= BR_NONE;
            bus_addr  <= '0;
            bus_wdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        EXEC: begin
          if (wr_acc) begin
            acc  <= res;
            zero <= (res == 4'h0);
          end
          if (wr_carry) carry <= c_new;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb_alu_bus_sequencer: directed vectors against a per-cycle scoreboard model.
// The bench acts as the register/operand provider and works with or without SEQ_TIMEOUT_EN.
module tb_alu_bus_sequencer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [3:0] busreq;
  logic [3:0] bus_addr;
  logic [3:0] bus_wdata;
  logic       bus_ack;
  logic [3:0] bus_rdata;
  logic [3:0] acc;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       err;

  alu_bus_sequencer #(.TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .busreq      (busreq),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .acc         (acc),
    .carry       (carry),
    .zero        (zero),
    .busy        (busy),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [3:0] regs [16];
  logic [3:0] exp_acc;
  logic       exp_carry;
  logic       exp_zero;
  logic       exp_busy;
  logic       exp_err;
  logic [3:0] exp_busreq;
  logic [3:0] exp_addr;
  logic [3:0] exp_wdata;

  function automatic void check(input string name, input logic [3:0] act,
                                input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("acc", acc, exp_acc);
      check("carry", {3'b0, carry}, {3'b0, exp_carry});
      check("zero", {3'b0, zero}, {3'b0, exp_zero});
      check("busy", {3'b0, busy}, {3'b0, exp_busy});
      check("err", {3'b0, err}, {3'b0, exp_err});
      check("busreq", busreq, exp_busreq);
      check("bus_addr", bus_addr, exp_addr);
      check("bus_wdata", bus_wdata, exp_wdata);
      check("instr_ready", {3'b0, instr_ready}, {3'b0, !exp_busy && ena});
    end
  end

  task automatic model_reset();
    exp_acc    = 4'h0;
    exp_carry  = 1'b0;
    exp_zero   = 1'b1;
    exp_busy   = 1'b0;
    exp_err    = 1'b0;
    exp_busreq = 4'h0;
    exp_addr   = 4'h0;
    exp_wdata  = 4'h0;
  endtask

  task automatic set_acc(input int v);
    exp_acc  = 4'(v);
    exp_zero = (4'(v) == 4'h0);
  endtask

  task automatic model_exec(input logic [3:0] op, input logic [3:0] f,
                            input logic [3:0] rd);
    int a;
    a = int'(exp_acc);
    case (op)
      4'h1: begin exp_carry = (a + int'(f)) > 15; set_acc(a + int'(f)); end
      4'h2: begin exp_carry = (a + int'(rd)) > 15; set_acc(a + int'(rd)); end
      4'h3: begin exp_carry = int'(rd) > a; set_acc(a - int'(rd)); end
      4'h4: set_acc(int'(exp_acc & rd));
      4'h5: set_acc(int'(exp_acc | rd));
      4'h6: set_acc(int'(exp_acc ^ rd));
      4'h7: set_acc(int'(f));
      4'h8: set_acc(int'(rd));
      4'h9: regs[f] = exp_acc;
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full instruction: d idle REQ cycles before ack; early holds ack from transfer on
  task automatic issue(input logic [7:0] ins, input int d,
                       input logic [3:0] opnd, input bit early,
                       input bit drop_ena);
    logic [3:0] op;
    logic [3:0] f;
    logic [3:0] rd;
    op = ins[3:0];
    f  = ins[7:4];
    rd = 4'h0;
    instr = ins;
    instr_valid = 1'b1;
    if (early) bus_ack = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = 8'h17;
    exp_busy = 1'b1;
    if (drop_ena) ena = 1'b0;
    tick();
    if ((op >= 4'h2 && op <= 4'h6) || op == 4'h8 || op == 4'h9) begin
      exp_busreq = (op == 4'h8) ? 4'h3 : (op == 4'h9) ? 4'h2 : 4'h1;
      exp_addr   = (op == 4'h8) ? 4'h0 : f;
      exp_wdata  = (op == 4'h9) ? exp_acc : 4'h0;
      rd = (op == 4'h8) ? opnd : regs[f];
      bus_rdata = ~rd;
      repeat (d) tick();
      bus_ack = 1'b1;
      bus_rdata = rd;
      tick();
      bus_ack = 1'b0;
      bus_rdata = ~rd;
      exp_busreq = 4'h0;
      exp_addr   = 4'h0;
      exp_wdata  = 4'h0;
      tick();
    end else begin
      tick();
    end
    bus_ack = 1'b0;
    model_exec(op, f, rd);
    exp_busy = 1'b0;
    if (drop_ena) begin
      check("ena_drop_ready", {3'b0, instr_ready}, 4'h0);
      ena = 1'b1;
    end
  endtask

  task automatic enter_req_rd(input logic [3:0] r);
    instr = {r, 4'h2};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    exp_busy = 1'b1;
    tick();
    exp_busreq = 4'h1;
    exp_addr = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    foreach (regs[i]) regs[i] = 4'(i);
    rst = 1'b1;
    ena = 1'b1;
    instr_valid = 1'b0;
    instr = 8'h00;
    bus_ack = 1'b0;
    bus_rdata = 4'h0;
    model_reset();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_acc", acc, 4'h0);
    check("rst_zero", {3'b0, zero}, 4'h1);
    check("rst_ready", {3'b0, instr_ready}, 4'h1);

    issue(8'h21, 0, 4'h0, 1'b0, 1'b0);
    check("addi2_acc", acc, 4'h2);
    issue(8'h31, 0, 4'h0, 1'b0, 1'b0);
    check("addi3_acc", acc, 4'h5);
    check("addi3_flags", {2'b0, carry, zero}, 4'h0);

    regs[1] = 4'h8;
    issue(8'h97, 0, 4'h0, 1'b0, 1'b0);
    issue(8'h12, 0, 4'h0, 1'b0, 1'b0);
    check("add_r1_acc", acc, 4'h1);
    check("add_r1_carry", {3'b0, carry}, 4'h1);
    issue(8'h97, 0, 4'h0, 1'b0, 1'b0);
    issue(8'h12, 4, 4'h0, 1'b0, 1'b0);
    check("add_r1_slow_acc", acc, 4'h1);

    issue(8'h08, 0, 4'hC, 1'b0, 1'b0);
    check("ldx_acc", acc, 4'hC);
    issue(8'h59, 2, 4'h0, 1'b0, 1'b0);
    check("st_r5_model", regs[5], 4'hC);
    issue(8'h52, 0, 4'h0, 1'b0, 1'b0);
    check("add_r5_acc", acc, 4'h8);

    regs[2] = 4'h3;
    issue(8'h37, 0, 4'h0, 1'b0, 1'b0);
    issue(8'h23, 1, 4'h0, 1'b0, 1'b0);
    check("sub_eq_acc", acc, 4'h0);
    check("sub_eq_flags", {2'b0, carry, zero}, 4'h1);
    issue(8'h27, 0, 4'h0, 1'b0, 1'b0);
    issue(8'h23, 0, 4'h0, 1'b0, 1'b0);
    check("sub_borrow_acc", acc, 4'hF);
    check("sub_borrow_carry", {3'b0, carry}, 4'h1);

    regs[3] = 4'h6;
    issue(8'hA7, 0, 4'h0, 1'b0, 1'b0);
    issue(8'h34, 0, 4'h0, 1'b1, 1'b0);
    issue(8'h35, 3, 4'h0, 1'b0, 1'b0);
    issue(8'h36, 0, 4'h0, 1'b0, 1'b0);
    check("xor_acc", acc, 4'h0);
    issue(8'h00, 0, 4'h0, 1'b1, 1'b0);
    issue(8'hFF, 0, 4'h0, 1'b1, 1'b0);
    issue(8'hE1, 0, 4'h0, 1'b0, 1'b1);
    check("ena_drop_acc", acc, 4'hE);

    ena = 1'b0;
    instr = 8'h51;
    instr_valid = 1'b1;
    repeat (3) tick();
    instr_valid = 1'b0;
    ena = 1'b1;
    tick();

    enter_req_rd(4'h1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rst_mid_busreq", busreq, 4'h0);
    check("rst_mid_busy", {3'b0, busy}, 4'h0);
    issue(8'h11, 0, 4'h0, 1'b0, 1'b0);
    check("rst_mid_addi1", acc, 4'h1);

`ifdef SEQ_TIMEOUT_EN
    enter_req_rd(4'h1);
    repeat (14) tick();
    check("timeout_pending", {3'b0, busy}, 4'h1);
    tick();
    exp_busy = 1'b0;
    exp_err = 1'b1;
    exp_busreq = 4'h0;
    exp_addr = 4'h0;
    check("timeout_err", {3'b0, err}, 4'h1);
    check("timeout_acc", acc, 4'h1);
    issue(8'h21, 0, 4'h0, 1'b0, 1'b0);
    check("after_timeout_acc", acc, 4'h3);
`else
    enter_req_rd(4'h1);
    repeat (100) tick();
    check("no_timeout_busy", {3'b0, busy}, 4'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
`endif
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
